// File: rtl/rf_write_arbiter.sv
// Round-robin write arbiter, one-hot read decoder and optional clear sweep for
// an 8-entry reg16 register file. Clear sweep is compiled in with `define RF_SWEEP_EN.
module rf_write_arbiter #(
  parameter int NREG = 8,
  parameter int W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic [2:0]      wa0,
  input  logic [2:0]      wa1,
  input  logic [W-1:0]    wd0,
  input  logic [W-1:0]    wd1,
  output logic            gnt0,
  output logic            gnt1,
  input  logic            clr,
  input  logic [2:0]      ra_a,
  input  logic [2:0]      ra_b,
  input  logic            rd_en,
  output logic [NREG-1:0] ld,
  output logic [W-1:0]    Din,
  output logic [NREG-1:0] oeA,
  output logic [NREG-1:0] oeB,
  output logic            busy
);
  localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

  logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic            rr_q, rr_d;
  logic [NREG-1:0] ld_q, ld_d;
  logic [W-1:0]    din_q, din_d;
  logic            elig0, elig1, arb_en;

`ifdef RF_SWEEP_EN
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;

  // busy covers both the pending cycle and the sweep itself
  assign arb_en = ~busy_q;
  assign busy   = busy_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign arb_en     = 1'b1;
  assign busy       = 1'b0;
`endif

  // A port granted this cycle is masked so it cannot be granted twice in a row
  assign elig0 = req0 & ~gnt0_q;
  assign elig1 = req1 & ~gnt1_q;

  always_comb begin
    gnt0_d = arb_en & elig0 & (~elig1 | ~rr_q);
    gnt1_d = arb_en & elig1 & (~elig0 | rr_q);
    rr_d   = rr_q;
    ld_d   = '0;
    din_d  = '0;
    if (gnt0_d) begin
      ld_d  = ONE_HOT0 << wa0;
      din_d = wd0;
      rr_d  = 1'b1;
    end else if (gnt1_d) begin
      ld_d  = ONE_HOT0 << wa1;
      din_d = wd1;
      rr_d  = 1'b0;
    end else begin
      ld_d  = '0;
      din_d = '0;
    end
`ifdef RF_SWEEP_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (busy_q) begin
          state_d = SWEEP;
          cnt_d   = 3'd0;
          ld_d    = ONE_HOT0;
        end else if (clr) begin
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      SWEEP: begin
        if (cnt_q == 3'd7) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          ld_d  = ONE_HOT0 << cnt_d;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        busy_d  = 1'b0;
      end
    endcase
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      rr_q   <= 1'b0;
      ld_q   <= '0;
      din_q  <= '0;
    end else begin
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      rr_q   <= rr_d;
      ld_q   <= ld_d;
      din_q  <= din_d;
    end
  end

`ifdef RF_SWEEP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end
`endif

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign ld   = ld_q;
  assign Din  = din_q;

  // Read decode is independent of the write FSM
  assign oeA = rd_en ? (ONE_HOT0 << ra_a) : '0;
  assign oeB = rd_en ? (ONE_HOT0 << ra_b) : '0;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected writes are queued when the
// stimulus is driven and compared as the DUT issues them; includes a reg16 file model.
module tb_rf_write_arbiter;
  logic        clk, reset, req0, req1, clr, rd_en;
  logic [2:0]  wa0, wa1, ra_a, ra_b;
  logic [15:0] wd0, wd1, Din;
  logic        gnt0, gnt1, busy;
  logic [7:0]  ld, oeA, oeB;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic [7:0]  ld;
    logic [15:0] din;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_obs, mon_exp;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] rf [8];
  logic [15:0] da, db;
  logic [7:0]  one8 = 8'h01;

  rf_write_arbiter #(.NREG(8), .W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .clr(clr),
    .ra_a(ra_a), .ra_b(ra_b), .rd_en(rd_en),
    .ld(ld), .Din(Din), .oeA(oeA), .oeB(oeB), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reg16 slices and the two tri-state read buses
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (ld[i]) rf[i] <= Din;
  end

  always_comb begin
    da = 16'h0000;
    db = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (oeA[i]) da = rf[i];
      if (oeB[i]) db = rf[i];
    end
  end

  // Scoreboard: every issued write must match the next queued expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (gnt0 && gnt1) begin
        err_cnt++;
        $display("FAIL double_grant: gnt0=%b gnt1=%b, required at most one", gnt0, gnt1);
      end
      if (gnt0 || gnt1 || ld != 8'h00) begin
        vec_cnt++;
        mon_obs = {gnt0, gnt1, ld, Din};
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_write: got gnt=%b%b ld=%h Din=%h, required none",
                   gnt0, gnt1, ld, Din);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_obs !== mon_exp) begin
            err_cnt++;
            $display("FAIL write: got gnt=%b%b ld=%h Din=%h, required gnt=%b%b ld=%h Din=%h",
                     mon_obs.g0, mon_obs.g1, mon_obs.ld, mon_obs.din,
                     mon_exp.g0, mon_exp.g1, mon_exp.ld, mon_exp.din);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b1; wa0 = 3'd3; wd0 = 16'hAAAA;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({gnt0, gnt1, ld, Din, busy} !== 27'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got gnt=%b%b ld=%h Din=%h busy=%b, required all 0",
               gnt0, gnt1, ld, Din, busy);
    end
    exp_q.push_back(wr_t'{1'b1, 1'b0, 8'h08, 16'hAAAA});
    reset = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (gnt0 !== 1'b1 || ld !== 8'h08 || Din !== 16'hAAAA) begin
      err_cnt++;
      $display("FAIL first_grant: got gnt0=%b ld=%h Din=%h, required 1 08 aaaa", gnt0, ld, Din);
    end
    req0 = 1'b0;
    @(negedge clk);
    rd_en = 1'b1; ra_a = 3'd3;
    #1;
    vec_cnt++;
    if (da !== 16'hAAAA) begin
      err_cnt++;
      $display("FAIL reset_readback: got DA=%h, required aaaa", da);
    end
  endtask

  task automatic test_alternate();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; wa0 = 3'd1; wd0 = 16'h5555;
    req1 = 1'b1; wa1 = 3'd2; wd1 = 16'hC3C3;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) exp_q.push_back(wr_t'{1'b1, 1'b0, 8'h02, 16'h5555});
      else            exp_q.push_back(wr_t'{1'b0, 1'b1, 8'h04, 16'hC3C3});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vec_cnt++;
      if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        err_cnt++;
        $display("FAIL alternate[%0d]: got gnt=%b%b, required %s", i, gnt0, gnt1,
                 (i % 2 == 0) ? "10" : "01");
      end
      if (i == 5) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    @(negedge clk);
    vec_cnt++;
    if ({gnt0, gnt1} !== 2'b00) begin
      err_cnt++;
      $display("FAIL alternate_stop: got gnt=%b%b, required 00", gnt0, gnt1);
    end
  endtask

  task automatic test_single_port();
    int n = 0;
    @(negedge clk);
    req1 = 1'b1; wa1 = 3'd4; wd1 = 16'h1234;
    for (int i = 0; i < 3; i++) exp_q.push_back(wr_t'{1'b0, 1'b1, 8'h10, 16'h1234});
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (gnt1) n++;
      if (i == 5) req1 = 1'b0;
    end
    vec_cnt++;
    if (n != 3) begin
      err_cnt++;
      $display("FAIL single_port_count: got %0d grants, required 3", n);
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    req0 = 1'b1; wa0 = 3'd5; wd0 = 16'h1111;
    exp_q.push_back(wr_t'{1'b1, 1'b0, 8'h20, 16'h1111});
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    rd_en = 1'b1; ra_b = 3'd5;
    req0 = 1'b1; wd0 = 16'h3C3C;
    exp_q.push_back(wr_t'{1'b1, 1'b0, 8'h20, 16'h3C3C});
    @(negedge clk);
    req0 = 1'b0;
    vec_cnt++;
    if (gnt0 !== 1'b1 || db !== 16'h1111) begin
      err_cnt++;
      $display("FAIL rdwr_old: got gnt0=%b DB=%h, required 1 1111", gnt0, db);
    end
    @(negedge clk);
    vec_cnt++;
    if (db !== 16'h3C3C) begin
      err_cnt++;
      $display("FAIL rdwr_new: got DB=%h, required 3c3c", db);
    end
  endtask

  task automatic test_read_decode();
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; ra_a = i[2:0]; ra_b = 3'(7 - i);
      #1;
      vec_cnt++;
      if (oeA !== (one8 << i) || oeB !== (one8 << (7 - i))) begin
        err_cnt++;
        $display("FAIL decode[%0d]: got oeA=%h oeB=%h, required %h %h", i, oeA, oeB,
                 one8 << i, one8 << (7 - i));
      end
    end
    ra_a = 3'd2; ra_b = 3'd2;
    #1;
    vec_cnt++;
    if (oeA !== 8'h04 || oeB !== 8'h04) begin
      err_cnt++;
      $display("FAIL decode_same: got oeA=%h oeB=%h, required 04 04", oeA, oeB);
    end
    rd_en = 1'b0;
    #1;
    vec_cnt++;
    if (oeA !== 8'h00 || oeB !== 8'h00) begin
      err_cnt++;
      $display("FAIL decode_disabled: got oeA=%h oeB=%h, required 00 00", oeA, oeB);
    end
  endtask

`ifdef RF_SWEEP_EN
  task automatic fill_all(input logic [15:0] d);
    bit got;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req0 = 1'b1; wa0 = i[2:0]; wd0 = d;
      exp_q.push_back(wr_t'{1'b1, 1'b0, one8 << i, d});
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
        @(negedge clk);
        if (gnt0) got = 1'b1;
      end
      req0 = 1'b0;
      vec_cnt++;
      if (!got) begin
        err_cnt++;
        $display("FAIL fill_timeout[%0d]: got no gnt0, required one", i);
      end
    end
  endtask

  task automatic test_sweep();
    bit got = 1'b0;
    logic [15:0] e;
    fill_all(16'hCCCC);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vec_cnt++;
    if (busy !== 1'b1 || ld !== 8'h00) begin
      err_cnt++;
      $display("FAIL sweep_pending: got busy=%b ld=%h, required 1 00", busy, ld);
    end
    req0 = 1'b1; wa0 = 3'd6; wd0 = 16'h7777;
    for (int i = 0; i < 8; i++) exp_q.push_back(wr_t'{1'b0, 1'b0, one8 << i, 16'h0000});
    exp_q.push_back(wr_t'{1'b1, 1'b0, 8'h40, 16'h7777});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (busy !== 1'b1 || ld !== (one8 << i) || Din !== 16'h0000 || {gnt0, gnt1} !== 2'b00) begin
        err_cnt++;
        $display("FAIL sweep_step[%0d]: got busy=%b ld=%h Din=%h gnt=%b%b, required 1 %h 0000 00",
                 i, busy, ld, Din, gnt0, gnt1, one8 << i);
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (busy !== 1'b0 || ld !== 8'h00) begin
      err_cnt++;
      $display("FAIL sweep_exit: got busy=%b ld=%h, required 0 00", busy, ld);
    end
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (gnt0) got = 1'b1;
    end
    req0 = 1'b0;
    vec_cnt++;
    if (!got) begin
      err_cnt++;
      $display("FAIL sweep_resume: got no gnt0 after sweep, required one");
    end
    @(negedge clk);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra_a = i[2:0]; ra_b = i[2:0];
      e = (i == 6) ? 16'h7777 : 16'h0000;
      #1;
      vec_cnt++;
      if (da !== e || db !== e) begin
        err_cnt++;
        $display("FAIL sweep_read[%0d]: got DA=%h DB=%h, required %h", i, da, db, e);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [15:0] e;
    fill_all(16'hCCCC);
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(wr_t'{1'b0, 1'b0, one8 << i, 16'h0000});
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (ld !== (one8 << i)) begin
        err_cnt++;
        $display("FAIL abort_step[%0d]: got ld=%h, required %h", i, ld, one8 << i);
      end
    end
    #1 reset = 1'b1;
    #1;
    vec_cnt++;
    if (ld !== 8'h00 || busy !== 1'b0 || {gnt0, gnt1} !== 2'b00) begin
      err_cnt++;
      $display("FAIL abort_immediate: got ld=%h busy=%b, required 00 0", ld, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vec_cnt++;
      if (ld !== 8'h00 || busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL abort_quiet[%0d]: got ld=%h busy=%b, required 00 0", k, ld, busy);
      end
    end
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra_a = i[2:0];
      e = (i < 4) ? 16'h0000 : 16'hCCCC;
      #1;
      vec_cnt++;
      if (da !== e) begin
        err_cnt++;
        $display("FAIL abort_read[%0d]: got DA=%h, required %h", i, da, e);
      end
    end
  endtask
`else
  task automatic test_clr_ignored();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vec_cnt++;
      if (busy !== 1'b0 || ld !== 8'h00) begin
        err_cnt++;
        $display("FAIL clr_ignored[%0d]: got busy=%b ld=%h, required 0 00", k, busy, ld);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; clr = 1'b0; rd_en = 1'b0;
    wa0 = 3'd0; wa1 = 3'd0; wd0 = 16'h0000; wd1 = 16'h0000;
    ra_a = 3'd0; ra_b = 3'd0;
    test_reset();
    test_alternate();
    test_single_port();
    test_read_during_write();
    test_read_decode();
`ifdef RF_SWEEP_EN
    test_sweep();
    test_reset_mid_sweep();
`else
    test_clr_ignored();
`endif
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
